// File: rtl/parser_pkg.sv
// Shared constants, tags and state encoding for the parser front end.
package parser_pkg;

  localparam int PARSER_HEAD_WIDTH = 512;
  localparam int DEF_DATA_WIDTH    = 128;
  localparam int BEATS             = PARSER_HEAD_WIDTH / DEF_DATA_WIDTH;

  localparam int TAG_START_BIT = 4;
  localparam int TAG_WIDTH     = TAG_START_BIT + 4;
  localparam int META_WIDTH    = 32;

  localparam logic [TAG_WIDTH-1:0] HEAD_TAG_SOP = {4'b1101, {TAG_START_BIT{1'b1}}};
  localparam logic [TAG_WIDTH-1:0] META_TAG_SOP = {4'b1111, {TAG_START_BIT{1'b0}}};

  typedef enum logic [1:0] {
    EXT_IDLE,
    EXT_COLLECT,
    EXT_SKIP
  } extract_state_t;

endpackage

// File: rtl/parser_sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module parser_sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_inc,
  output logic [CNT_WIDTH-1:0] o_count
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_count <= '0;
    end else if (i_inc) begin
      o_count <= sat_inc(o_count);
    end
  end

endmodule

// File: rtl/parser_head_extractor.sv
// Collects the first HEAD_WIDTH bits of each packet from the beat stream and
// emits them as a single tagged head/meta pulse, with good/error statistics.
module parser_head_extractor
  import parser_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int HEAD_WIDTH = PARSER_HEAD_WIDTH,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_data_valid,
  input  logic                            i_data_sop,
  input  logic                            i_data_eop,
  input  logic [3:0]                      i_data_mod,
  input  logic [DATA_WIDTH-1:0]           i_data,
  output logic [HEAD_WIDTH+TAG_WIDTH-1:0] o_head,
  output logic [META_WIDTH+TAG_WIDTH-1:0] o_meta,
  output logic [CNT_WIDTH-1:0]            o_pkt_cnt,
  output logic [CNT_WIDTH-1:0]            o_err_cnt
);

  localparam int NUM_BEATS = HEAD_WIDTH / DATA_WIDTH;
  localparam int IDX_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int NBYTES    = DATA_WIDTH / 8;

  // Keeps bytes below mod (byte 0 at the MSB end); mod 0 keeps the whole beat.
  function automatic logic [DATA_WIDTH-1:0] byte_mask(input logic [3:0] mod);
    logic [DATA_WIDTH-1:0] m;
    m = '1;
    if (mod != 4'd0) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (b >= int'(mod)) m[DATA_WIDTH-1-8*b -: 8] = 8'h00;
      end
    end
    return m;
  endfunction

  function automatic logic [HEAD_WIDTH-1:0] put_beat(input logic [HEAD_WIDTH-1:0] h,
                                                     input logic [IDX_W-1:0]      slot,
                                                     input logic [DATA_WIDTH-1:0] beat);
    logic [HEAD_WIDTH-1:0] r;
    r = h;
    for (int i = 0; i < NUM_BEATS; i++) begin
      if (slot == IDX_W'(i)) r[HEAD_WIDTH-1-DATA_WIDTH*i -: DATA_WIDTH] = beat;
    end
    return r;
  endfunction

  extract_state_t          state, state_n;
  logic [IDX_W-1:0]        idx, idx_n;
  logic [HEAD_WIDTH-1:0]   head_buf, head_n;
  logic [DATA_WIDTH-1:0]   beat_p0;
  logic                    emit_p0, err_p0, start_p0;
  logic                    vld_p1;
  logic [HEAD_WIDTH-1:0]   head_p1;

  assign beat_p0 = i_data_eop ? (i_data & byte_mask(i_data_mod)) : i_data;

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    head_n   = head_buf;
    emit_p0  = 1'b0;
    err_p0   = 1'b0;
    start_p0 = 1'b0;
    if (i_data_valid) begin
      unique case (state)
        EXT_IDLE: begin
          if (i_data_sop) start_p0 = 1'b1;
          else            err_p0   = 1'b1;
        end
        EXT_COLLECT: begin
          if (i_data_sop) begin
            // Previous packet lost its eop: drop its partial head unsent.
            err_p0   = 1'b1;
            start_p0 = 1'b1;
          end else begin
            head_n = put_beat(head_buf, idx, beat_p0);
            if (i_data_eop) begin
              emit_p0 = 1'b1;
              state_n = EXT_IDLE;
              idx_n   = '0;
            end else if (idx == IDX_W'(NUM_BEATS-1)) begin
              emit_p0 = 1'b1;
              state_n = EXT_SKIP;
              idx_n   = '0;
            end else begin
              idx_n = idx + IDX_W'(1);
            end
          end
        end
        EXT_SKIP: begin
          if (i_data_sop) begin
            err_p0   = 1'b1;
            start_p0 = 1'b1;
          end else if (i_data_eop) begin
            state_n = EXT_IDLE;
          end
        end
        default: state_n = EXT_IDLE;
      endcase

      if (start_p0) begin
        head_n = put_beat('0, '0, beat_p0);
        if (i_data_eop) begin
          emit_p0 = 1'b1;
          state_n = EXT_IDLE;
          idx_n   = '0;
        end else if (NUM_BEATS == 1) begin
          emit_p0 = 1'b1;
          state_n = EXT_SKIP;
          idx_n   = '0;
        end else begin
          state_n = EXT_COLLECT;
          idx_n   = IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= EXT_IDLE;
      idx      <= '0;
      head_buf <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      head_buf <= head_n;
    end
  end

  // ---- p1: registered emit pulse ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p1  <= 1'b0;
      head_p1 <= '0;
    end else begin
      vld_p1  <= emit_p0;
      head_p1 <= emit_p0 ? head_n : '0;
    end
  end

  assign o_head = vld_p1 ? {HEAD_TAG_SOP, head_p1} : '0;
  assign o_meta = vld_p1 ? {META_TAG_SOP, {META_WIDTH{1'b0}}} : '0;

  parser_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_pkt_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (emit_p0),
    .o_count (o_pkt_cnt)
  );

  parser_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_err_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (err_p0),
    .o_count (o_err_cnt)
  );

endmodule

// File: tb/tb_parser_head_extractor.sv
// Directed bench for parser_head_extractor; narrow counters make saturation reachable.
module tb_parser_head_extractor;

  localparam int DW  = 128;
  localparam int HW  = 512;
  localparam int CW  = 4;
  localparam int TW  = 8;
  localparam int MW  = 32;
  localparam logic [TW-1:0] HTAG = 8'hDF;
  localparam logic [TW-1:0] MTAG = 8'hF0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vld = 1'b0;
  logic          sop = 1'b0;
  logic          eop = 1'b0;
  logic [3:0]    mod = 4'd0;
  logic [DW-1:0] data = '0;
  logic [HW+TW-1:0] o_head;
  logic [MW+TW-1:0] o_meta;
  logic [CW-1:0]    o_pkt_cnt;
  logic [CW-1:0]    o_err_cnt;

  int errors = 0;
  int checks = 0;

  parser_head_extractor #(.DATA_WIDTH(DW), .HEAD_WIDTH(HW), .CNT_WIDTH(CW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_data_valid (vld),
    .i_data_sop   (sop),
    .i_data_eop   (eop),
    .i_data_mod   (mod),
    .i_data       (data),
    .o_head       (o_head),
    .o_meta       (o_meta),
    .o_pkt_cnt    (o_pkt_cnt),
    .o_err_cnt    (o_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [HW+TW-1:0] obs, input logic [HW+TW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic s, input logic e, input logic [3:0] m, input logic [DW-1:0] d);
    vld = 1'b1; sop = s; eop = e; mod = m; data = d;
    @(posedge clk); #1;
    vld = 1'b0; sop = 1'b0; eop = 1'b0; mod = 4'd0; data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  localparam logic [DW-1:0] A0 = 128'h000a3500_11223344_55667788_99aa4500;
  localparam logic [DW-1:0] A1 = 128'h45000034_12344000_40067777_c0a80001;
  localparam logic [DW-1:0] A2 = 128'hc0a80002_1f900050_00000001_00000002;
  localparam logic [DW-1:0] A3 = 128'h5010ffff_abcd0000_deadbeef_cafef00d;
  localparam logic [DW-1:0] B0 = 128'h0123456789abcdef_fedcba9876543210;
  localparam logic [DW-1:0] C0 = 128'h11111111_22222222_33333333_44444444;
  localparam logic [DW-1:0] C1 = 128'h55555555_66666666_77777777_88888888;
  localparam logic [DW-1:0] C2 = 128'h01020304_05060708_f1f2f3f4_f5f6f7f8;
  localparam logic [DW-1:0] D4 = 128'haaaaaaaa_aaaaaaaa_aaaaaaaa_aaaaaaaa;
  localparam logic [DW-1:0] D5 = 128'hbbbbbbbb_bbbbbbbb_bbbbbbbb_bbbbbbbb;
  localparam logic [DW-1:0] E0 = 128'h0e0e0e0e_0e0e0e0e_0e0e0e0e_0e0e0e01;
  localparam logic [DW-1:0] E1 = 128'h0e0e0e0e_0e0e0e0e_0e0e0e0e_0e0e0e02;
  localparam logic [DW-1:0] E2 = 128'h0e0e0e0e_0e0e0e0e_0e0e0e0e_0e0e0e03;
  localparam logic [DW-1:0] E3 = 128'h0e0e0e0e_0e0e0e0e_0e0e0e0e_0e0e0e04;

  logic [HW+TW-1:0] meta_exp;

  initial begin
    meta_exp = '0;
    meta_exp[MW+TW-1:0] = {MTAG, {MW{1'b0}}};

    // reset state
    @(posedge clk); #1;
    do_reset();
    chk("rst_head", o_head, '0);
    chk("rst_meta", o_meta, '0);
    chk("rst_pkt", o_pkt_cnt, '0);
    chk("rst_err", o_err_cnt, '0);

    // 64B packet, 4 beats
    send(1, 0, 0, A0);
    send(0, 0, 0, A1);
    send(0, 0, 0, A2);
    chk("t1_mid_head", o_head, '0);
    send(0, 1, 0, A3);
    chk("t1_head", o_head, {HTAG, A0, A1, A2, A3});
    chk("t1_meta", o_meta, meta_exp);
    chk("t1_pkt", o_pkt_cnt, 1);
    chk("t1_err", o_err_cnt, 0);

    // 16B single beat
    send(1, 1, 0, B0);
    chk("t2_head", o_head, {HTAG, B0, 384'h0});
    @(posedge clk); #1;
    chk("t2_idle_head", o_head, '0);
    chk("t2_idle_meta", o_meta, '0);

    // 40B packet, mod=8 on the last beat
    send(1, 0, 0, C0);
    send(0, 0, 0, C1);
    send(0, 1, 4'd8, C2);
    chk("t3_head", o_head, {HTAG, C0, C1, 64'h01020304_05060708, 64'h0, 128'h0});
    chk("t3_pkt", o_pkt_cnt, 3);
    chk("t3_err", o_err_cnt, 0);

    // 96B packet: emit at beat 3, skip tail, back-to-back next packet
    do_reset();
    chk("t4_rst_pkt", o_pkt_cnt, 0);
    send(1, 0, 0, A0);
    send(0, 0, 0, A1);
    send(0, 0, 0, A2);
    send(0, 0, 0, A3);
    chk("t4_head", o_head, {HTAG, A0, A1, A2, A3});
    chk("t4_pkt1", o_pkt_cnt, 1);
    send(0, 0, 0, D4);
    chk("t4_skip4", o_head, '0);
    send(0, 1, 0, D5);
    chk("t4_skip5", o_head, '0);
    send(1, 1, 0, B0);
    chk("t4_next_head", o_head, {HTAG, B0, 384'h0});
    chk("t4_pkt2", o_pkt_cnt, 2);
    chk("t4_err", o_err_cnt, 0);

    // missing eop: aborted head is never emitted
    send(1, 0, 0, A0);
    send(0, 0, 0, A1);
    send(1, 0, 0, E0);
    chk("t5_abort_head", o_head, '0);
    chk("t5_err", o_err_cnt, 1);
    send(0, 0, 0, E1);
    send(0, 0, 0, E2);
    send(0, 1, 0, E3);
    chk("t5_head", o_head, {HTAG, E0, E1, E2, E3});
    chk("t5_pkt", o_pkt_cnt, 3);

    // reset mid-packet, orphan tail, then error counter saturation
    send(1, 0, 0, A0);
    send(0, 0, 0, A1);
    do_reset();
    chk("t6_rst_head", o_head, '0);
    chk("t6_rst_err", o_err_cnt, 0);
    chk("t6_rst_pkt", o_pkt_cnt, 0);
    send(0, 0, 0, A2);
    chk("t6_orphan_head", o_head, '0);
    send(0, 1, 0, A3);
    chk("t6_orphan_head2", o_head, '0);
    chk("t6_err2", o_err_cnt, 2);
    chk("t6_pkt", o_pkt_cnt, 0);
    for (int i = 0; i < 13; i++) send(0, 0, 0, D4);
    chk("t6_err_full", o_err_cnt, 15);
    send(0, 0, 0, D5);
    chk("t6_err_sat", o_err_cnt, 15);
    // invalid cycles with sop asserted must be ignored
    sop = 1'b1; eop = 1'b1; data = B0;
    @(posedge clk); #1;
    sop = 1'b0; eop = 1'b0; data = '0;
    chk("t6_novalid_head", o_head, '0);
    chk("t6_novalid_pkt", o_pkt_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
